// File: rtl/aaska_stim_seq_if.sv
// Configuration and drive bundle for the biphasic stimulation sequencer.
// The controller holds the master side; the sequencer holds the slave side.
interface aaska_stim_seq_if #(
    parameter int ELEC_NUM = 31
);
    logic                enable;
    logic [5:0]          amplitude;
    logic [11:0]         freq;
    logic [2:0]          phase_dur;
    logic [5:0]          ramp;
    logic [9:0]          ramp_factor;
    logic [7:0]          on_time;
    logic [9:0]          off_time;
    logic [ELEC_NUM:0]   electrode1;
    logic [ELEC_NUM:0]   electrode2;
    logic [ELEC_NUM:0]   up_switches;
    logic [ELEC_NUM:0]   down_switches;
    logic [5:0]          DAC;
    logic                pulse_active;

    modport master (
        output enable, amplitude, freq, phase_dur, ramp, ramp_factor,
               on_time, off_time, electrode1, electrode2,
        input  up_switches, down_switches, DAC, pulse_active
    );

    modport slave (
        input  enable, amplitude, freq, phase_dur, ramp, ramp_factor,
               on_time, off_time, electrode1, electrode2,
        output up_switches, down_switches, DAC, pulse_active
    );
endinterface

// File: rtl/aaska_stim_seq.sv
// Biphasic H-bridge stimulation sequencer: PH1 / GAP / PH2 / WAIT periods grouped
// into ramped ON bursts separated by silent OFF stretches.
module aaska_stim_seq #(
    parameter int ELEC_NUM = 31
) (
    input  logic            clk,
    input  logic            reset,
    aaska_stim_seq_if.slave bus
);
    localparam int EW = ELEC_NUM + 1;

    typedef enum logic [2:0] {S_IDLE, S_PH1, S_GAP, S_PH2, S_WAIT, S_OFF} state_t;

    state_t        r_state;
    logic [11:0]   r_tcnt;
    logic [11:0]   r_T;
    logic [2:0]    r_P;
    logic [9:0]    r_offcnt;
    logic [9:0]    r_off;
    logic [7:0]    r_on;
    logic [7:0]    r_n;
    logic [9:0]    r_raw;
    logic [EW-1:0] r_e1, r_e2;
    logic [EW-1:0] r_up, r_dn;
    logic [5:0]    r_dac;
    logic          r_act;
    logic          r_stop;

    logic [2:0]    w_P_in;
    logic [11:0]   w_min_T, w_T_in, w_P12, w_2P;
    logic [EW-1:0] w_e1m, w_e2m;
    logic [7:0]    w_n_new;
    logic [10:0]   w_sum;
    logic [9:0]    w_raw_new, w_amp16;
    logic [5:0]    w_dac_new;
    logic          w_burst_end, w_start, w_new_burst;

    always_comb begin
        w_P_in      = (bus.phase_dur == 3'd0) ? 3'd1 : bus.phase_dur;
        w_min_T     = {8'd0, w_P_in, 1'b0} + 12'd2;
        w_T_in      = (bus.freq < w_min_T) ? w_min_T : bus.freq;
        w_P12       = {9'd0, r_P};
        w_2P        = {8'd0, r_P, 1'b0};
        // shorted electrodes are dropped from both bridge sides
        w_e1m       = bus.electrode1 & ~bus.electrode2;
        w_e2m       = bus.electrode2 & ~bus.electrode1;
        w_burst_end = (r_on != 8'd0) && (r_off != 10'd0) && (r_n >= r_on);

        w_start     = 1'b0;
        w_new_burst = 1'b0;
        case (r_state)
            S_IDLE: if (bus.enable) begin
                w_start     = 1'b1;
                w_new_burst = 1'b1;
            end
            S_WAIT: if (bus.enable && r_tcnt == r_T - 12'd1 && !w_burst_end)
                w_start = 1'b1;
            S_OFF: if (bus.enable && r_tcnt == r_T - 12'd1 && r_offcnt == r_off - 10'd1) begin
                w_start     = 1'b1;
                w_new_burst = 1'b1;
            end
            default: ;
        endcase

        w_n_new   = w_new_burst ? 8'd1 : ((r_n == 8'hFF) ? r_n : r_n + 8'd1);
        // n*ramp_factor built incrementally, pinned at full scale instead of wrapping
        w_sum     = {1'b0, (w_new_burst ? 10'd0 : r_raw)} + {1'b0, bus.ramp_factor};
        w_raw_new = w_sum[10] ? 10'h3FF : w_sum[9:0];
        w_amp16   = {bus.amplitude, 4'd0};
        w_dac_new = bus.amplitude;
        if (w_n_new <= {2'd0, bus.ramp} && w_raw_new < w_amp16)
            w_dac_new = w_raw_new[9:4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_tcnt   <= '0;
            r_T      <= '0;
            r_P      <= '0;
            r_offcnt <= '0;
            r_off    <= '0;
            r_on     <= '0;
            r_n      <= '0;
            r_raw    <= '0;
            r_e1     <= '0;
            r_e2     <= '0;
            r_up     <= '0;
            r_dn     <= '0;
            r_dac    <= '0;
            r_act    <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_up   <= '0;
            r_dn   <= '0;
            r_dac  <= '0;
            r_act  <= 1'b0;
            r_tcnt <= r_tcnt + 12'd1;
            case (r_state)
                S_IDLE: r_tcnt <= '0;
                S_PH1: begin
                    r_act <= 1'b1;
                    r_dac <= r_dac;
                    if (!bus.enable) r_stop <= 1'b1;
                    if (r_tcnt == w_P12 - 12'd1) begin
                        r_state <= S_GAP;
                    end else begin
                        r_up <= r_e1;
                        r_dn <= r_e2;
                    end
                end
                S_GAP: begin
                    r_act   <= 1'b1;
                    r_dac   <= r_dac;
                    r_up    <= r_e2;
                    r_dn    <= r_e1;
                    r_state <= S_PH2;
                    if (!bus.enable) r_stop <= 1'b1;
                end
                S_PH2: begin
                    if (!bus.enable) r_stop <= 1'b1;
                    if (r_tcnt == w_2P) begin
                        // a pulse always finishes; a dropped enable takes effect only here
                        r_state <= (r_stop || !bus.enable) ? S_IDLE : S_WAIT;
                    end else begin
                        r_act <= 1'b1;
                        r_dac <= r_dac;
                        r_up  <= r_e2;
                        r_dn  <= r_e1;
                    end
                end
                S_WAIT: begin
                    if (!bus.enable) begin
                        r_state <= S_IDLE;
                    end else if (r_tcnt == r_T - 12'd1 && w_burst_end) begin
                        r_state  <= S_OFF;
                        r_tcnt   <= '0;
                        r_offcnt <= '0;
                    end
                end
                S_OFF: begin
                    if (!bus.enable) begin
                        r_state <= S_IDLE;
                    end else if (r_tcnt == r_T - 12'd1) begin
                        r_tcnt   <= '0;
                        r_offcnt <= r_offcnt + 10'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // every PH1 entry re-latches the period's configuration
            if (w_start) begin
                r_state <= S_PH1;
                r_tcnt  <= '0;
                r_stop  <= 1'b0;
                r_P     <= w_P_in;
                r_T     <= w_T_in;
                r_on    <= bus.on_time;
                r_off   <= bus.off_time;
                r_e1    <= w_e1m;
                r_e2    <= w_e2m;
                r_n     <= w_n_new;
                r_raw   <= w_raw_new;
                r_up    <= w_e1m;
                r_dn    <= w_e2m;
                r_dac   <= w_dac_new;
                r_act   <= 1'b1;
            end
        end
    end

    assign bus.up_switches   = r_up;
    assign bus.down_switches = r_dn;
    assign bus.DAC           = r_dac;
    assign bus.pulse_active  = r_act;
endmodule
